// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge
// ---------------------------------------------------------------------------
// Serial debug/loader bridge. Framed commands arrive on an 8N1 UART line and
// are turned into single-word transactions on the picorv32 native memory bus,
// where this block acts as a second initiator beside the CPU. Status and read
// data go back over the same UART.
//
// Command protocol (multi-byte fields little-endian):
//   'W' (0x57) addr[4] data[4] -> word write, reply 'K' (0x4B)
//   'R' (0x52) addr[4]         -> word read,  reply rdata[4], LSB first
//   anything else              -> reply '?' (0x3F)
//   bus timeout                -> reply 'E' (0x45)
//
// Ports:
//   clk, resetn   system clock, synchronous active-low reset
//   ser_rx        serial input (asynchronous, idle high)
//   ser_tx        serial output (idle high)
//   mem_valid     bus request
//   mem_addr      word address, bits [1:0] forced to 0
//   mem_wdata     write data
//   mem_wstrb     4'b1111 for write, 4'b0000 for read or when idle
//   mem_ready     responder acknowledge
//   mem_rdata     read data, valid with mem_ready
//   busy          high from first command byte until the last reply byte ends
//   dbg_state     current command FSM state (IDLE=0, CMD_ADDR=1, CMD_DATA=2,
//                 BUS=3, RESP=4)
//
// Bus handshake: mem_valid is raised together with mem_addr/mem_wdata/
// mem_wstrb and all four are held stable until a posedge where mem_valid and
// mem_ready are both high; that edge completes the transfer, captures
// mem_rdata, and mem_valid is low from the next cycle. mem_ready seen while
// mem_valid is low has no effect.
// ---------------------------------------------------------------------------
module uart_bus_bridge #(
  parameter int UART_CLK        = 12000000,
  parameter int BAUD_RATE       = 115200,
  parameter int RX_TIMEOUT_BITS = 100,
  parameter int BUS_TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ser_rx,
  output logic        ser_tx,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  // 8x oversampling tick shared by receiver and transmitter
  localparam int DIV      = UART_CLK / (BAUD_RATE * 8);
  localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TO_TICKS = RX_TIMEOUT_BITS * 8;
  localparam int TO_W     = $clog2(TO_TICKS + 1);
  localparam int BT_W     = $clog2(BUS_TIMEOUT + 1);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_UNK   = 8'h3F;
  localparam logic [7:0] RSP_ERR   = 8'h45;

  // -------------------------------------------------------------------------
  // Free-running tick generator
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0] tick_cnt;
  logic             tick;

  assign tick = (tick_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Receiver: 2-flop synchroniser, start detect/confirm, 8 data, 1 stop
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  rx_state_t   rx_state;
  logic        rx_meta;
  logic        rx_sync;
  logic [2:0]  rx_tcnt;
  logic [2:0]  rx_bitn;
  logic [7:0]  rx_shift;
  logic [7:0]  rx_byte;
  logic        rx_valid;  // one-cycle pulse: rx_byte holds a good byte
  logic        rx_ferr;   // one-cycle pulse: stop bit was low

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
    end else begin
      rx_meta  <= ser_rx;
      rx_sync  <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_state <= RX_IDLE;
      rx_tcnt  <= '0;
      rx_bitn  <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (tick) begin
        case (rx_state)
          RX_IDLE: begin
            if (!rx_sync) begin
              rx_state <= RX_START;
              rx_tcnt  <= '0;
            end
          end
          // Re-check the line half a bit after the edge; a glitch that has
          // already gone high is not a start bit.
          RX_START: begin
            if (rx_tcnt == 3'd3) begin
              if (!rx_sync) begin
                rx_state <= RX_DATA;
                rx_tcnt  <= '0;
                rx_bitn  <= '0;
              end else begin
                rx_state <= RX_IDLE;
              end
            end else begin
              rx_tcnt <= rx_tcnt + 1'b1;
            end
          end
          // rx_tcnt wraps 7 -> 0, so each sample lands one bit after the last
          RX_DATA: begin
            rx_tcnt <= rx_tcnt + 1'b1;
            if (rx_tcnt == 3'd7) begin
              rx_shift <= {rx_sync, rx_shift[7:1]};
              rx_bitn  <= rx_bitn + 1'b1;
              if (rx_bitn == 3'd7) begin
                rx_state <= RX_STOP;
              end
            end
          end
          RX_STOP: begin
            rx_tcnt <= rx_tcnt + 1'b1;
            if (rx_tcnt == 3'd7) begin
              if (rx_sync) begin
                rx_valid <= 1'b1;
                rx_byte  <= rx_shift;
              end else begin
                rx_ferr  <= 1'b1;
              end
              rx_state <= RX_IDLE;
            end
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Command FSM with bus initiator and reply transmitter
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD_ADDR = 3'd1,
    CMD_DATA = 3'd2,
    BUS      = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t           state;
  logic             is_write;
  logic [1:0]       byte_cnt;
  logic [31:0]      addr_r;
  logic [31:0]      data_r;
  logic [TO_W-1:0]  to_cnt;
  logic [BT_W-1:0]  bus_cnt;
  logic [31:0]      resp_buf;
  logic [2:0]       resp_left;
  logic             tx_active;
  logic [2:0]       tx_tcnt;
  logic [3:0]       tx_bitn;
  logic [8:0]       tx_shift;

  // Fields arrive LSB first, so shifting each new byte in from the top
  // leaves the full little-endian word in place after the fourth byte.
  logic [31:0] addr_full;
  logic [31:0] data_full;

  assign addr_full = {rx_byte, addr_r[31:8]};
  assign data_full = {rx_byte, data_r[31:8]};
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      is_write  <= 1'b0;
      byte_cnt  <= '0;
      addr_r    <= '0;
      data_r    <= '0;
      to_cnt    <= '0;
      bus_cnt   <= '0;
      resp_buf  <= '0;
      resp_left <= '0;
      tx_active <= 1'b0;
      tx_tcnt   <= '0;
      tx_bitn   <= '0;
      tx_shift  <= '1;
      ser_tx    <= 1'b1;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_active <= 1'b0;
          if (rx_valid) begin
            busy     <= 1'b1;
            byte_cnt <= '0;
            to_cnt   <= TO_W'(TO_TICKS);
            if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
              is_write <= (rx_byte == CMD_WRITE);
              state    <= CMD_ADDR;
            end else begin
              resp_buf  <= {24'h0, RSP_UNK};
              resp_left <= 3'd1;
              state     <= RESP;
            end
          end
        end

        CMD_ADDR: begin
          if (rx_ferr) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rx_valid) begin
            addr_r   <= addr_full;
            to_cnt   <= TO_W'(TO_TICKS);
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) begin
              if (is_write) begin
                state <= CMD_DATA;
              end else begin
                mem_valid <= 1'b1;
                mem_addr  <= {addr_full[31:2], 2'b00};
                mem_wdata <= '0;
                mem_wstrb <= 4'b0000;
                bus_cnt   <= '0;
                state     <= BUS;
              end
            end
          end else if (tick) begin
            if (to_cnt == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              to_cnt <= to_cnt - 1'b1;
            end
          end
        end

        CMD_DATA: begin
          if (rx_ferr) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rx_valid) begin
            data_r   <= data_full;
            to_cnt   <= TO_W'(TO_TICKS);
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) begin
              mem_valid <= 1'b1;
              mem_addr  <= {addr_r[31:2], 2'b00};
              mem_wdata <= data_full;
              mem_wstrb <= 4'b1111;
              bus_cnt   <= '0;
              state     <= BUS;
            end
          end else if (tick) begin
            if (to_cnt == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              to_cnt <= to_cnt - 1'b1;
            end
          end
        end

        // mem_valid is always high in this state, so mem_ready alone marks
        // the completing edge.
        BUS: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_wstrb <= 4'b0000;
            resp_buf  <= is_write ? {24'h0, RSP_OK} : mem_rdata;
            resp_left <= is_write ? 3'd1 : 3'd4;
            state     <= RESP;
          end else if (bus_cnt == BT_W'(BUS_TIMEOUT - 1)) begin
            mem_valid <= 1'b0;
            mem_wstrb <= 4'b0000;
            resp_buf  <= {24'h0, RSP_ERR};
            resp_left <= 3'd1;
            state     <= RESP;
          end else begin
            bus_cnt <= bus_cnt + 1'b1;
          end
        end

        // tx_shift holds {stop, data}; tx_bitn counts bits shifted out after
        // the start bit, and reaching 9 means the stop bit has finished.
        RESP: begin
          if (!tx_active) begin
            if (tick) begin
              ser_tx    <= 1'b0;
              tx_active <= 1'b1;
              tx_shift  <= {1'b1, resp_buf[7:0]};
              resp_buf  <= resp_buf >> 8;
              resp_left <= resp_left - 1'b1;
              tx_tcnt   <= '0;
              tx_bitn   <= '0;
            end
          end else if (tick) begin
            tx_tcnt <= tx_tcnt + 1'b1;
            if (tx_tcnt == 3'd7) begin
              if (tx_bitn != 4'd9) begin
                ser_tx   <= tx_shift[0];
                tx_shift <= {1'b1, tx_shift[8:1]};
                tx_bitn  <= tx_bitn + 1'b1;
              end else if (resp_left != 3'd0) begin
                // next byte starts immediately, no idle bits in between
                ser_tx    <= 1'b0;
                tx_shift  <= {1'b1, resp_buf[7:0]};
                resp_buf  <= resp_buf >> 8;
                resp_left <= resp_left - 1'b1;
                tx_bitn   <= '0;
              end else begin
                tx_active <= 1'b0;
                state     <= IDLE;
                busy      <= 1'b0;
              end
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
